// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the sar_search binary-search initiator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
`timescale 1ns/1ps
package sar_search_pkg;

    // Default operand width and the matching probe-counter width.
    localparam int SAR_W   = 4;
    localparam int STEPS_W = $clog2(SAR_W + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Midpoint of the current bounds; callers truncate to the operand width.
    // Operands are far below 2^31, so the 32-bit sum never overflows.
    function automatic logic [31:0] mid(input logic [31:0] lo, input logic [31:0] hi);
        logic [31:0] sum;
        sum = lo + hi;
        return sum >> 1;
    endfunction

    // A sane comparator answer has exactly one of g/e/s set.
    function automatic logic onehot3(input logic g, input logic e, input logic s);
        return ({g, e, s} == 3'b100) || ({g, e, s} == 3'b010) || ({g, e, s} == 3'b001);
    endfunction

endpackage

// File: rtl/full_comp.sv
// Combinational magnitude comparator answering the sar_search probes.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs always track the inputs.
`timescale 1ns/1ps
module full_comp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             g,
    output logic             e,
    output logic             s
);

    // Exactly one of g/e/s is high for any a/b pair.
    always_comb begin
        g = (a > b);
        e = (a == b);
        s = (a < b);
    end

endmodule

// File: rtl/sar_search.sv
// Binary-search initiator probing an external comparator; SAR_SEARCH_STEP_CNT_EN adds the probe counter.
// Latency: start sampled in IDLE, done/error pulse probes+1 cycles later (worst case WIDTH+2).
// Backpressure: none; start outside IDLE is dropped, the comparator must answer in the same cycle.
`timescale 1ns/1ps
module sar_search
    import sar_search_pkg::*;
#(
    parameter  int WIDTH = SAR_W,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_g,
    input  logic             cmp_e,
    input  logic             cmp_s,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] steps
);

    localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   ONE_W1     = {{WIDTH{1'b0}}, 1'b1};

    state_t           state, state_nxt;
    // Bounds carry one extra bit so lo can reach 2^WIDTH and hi can underflow visibly.
    logic [WIDTH:0]   lo, hi, lo_nxt, hi_nxt;
    logic [WIDTH-1:0] guess_nxt, result_nxt;
    logic             pend_err, pend_err_nxt;
    logic             resp_ok;

    assign resp_ok = onehot3(cmp_g, cmp_e, cmp_s);

    // Next-state, bound narrowing and next probe selection.
    always_comb begin
        state_nxt    = state;
        lo_nxt       = lo;
        hi_nxt       = hi;
        guess_nxt    = guess;
        result_nxt   = result;
        pend_err_nxt = pend_err;
        case (state)
            IDLE: begin
                if (start) begin
                    lo_nxt       = '0;
                    hi_nxt       = HI_INIT;
                    guess_nxt    = GUESS_INIT;
                    pend_err_nxt = 1'b0;
                    state_nxt    = PROBE;
                end
            end
            PROBE: begin
                if (!resp_ok) begin
                    pend_err_nxt = 1'b1;
                    state_nxt    = FINISH;
                end else if (cmp_e) begin
                    result_nxt   = guess;
                    pend_err_nxt = 1'b0;
                    state_nxt    = FINISH;
                end else begin
                    if (cmp_g) begin
                        lo_nxt = {1'b0, guess} + ONE_W1;
                    end else begin
                        hi_nxt = {1'b0, guess} - ONE_W1;
                    end
                    // Empty interval or a wrapped hi means the answers contradict each other.
                    if ((lo_nxt > hi_nxt) || hi_nxt[WIDTH]) begin
                        pend_err_nxt = 1'b1;
                        state_nxt    = FINISH;
                    end else begin
                        guess_nxt = WIDTH'(mid(32'(lo_nxt), 32'(hi_nxt)));
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Search state registers; reset aborts any search without a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            guess    <= '0;
            result   <= '0;
            pend_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            lo       <= lo_nxt;
            hi       <= hi_nxt;
            guess    <= guess_nxt;
            result   <= result_nxt;
            pend_err <= pend_err_nxt;
        end
    end

    assign busy  = (state == PROBE);
    assign done  = (state == FINISH) && !pend_err;
    assign error = (state == FINISH) &&  pend_err;

`ifdef SAR_SEARCH_STEP_CNT_EN
    // Probe counter: cleared on an accepted start, bumped once per PROBE cycle, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps <= '0;
        end else if ((state == IDLE) && start) begin
            steps <= '0;
        end else if (state == PROBE) begin
            steps <= steps + CNT_W'(1);
        end
    end
`else
    assign steps = '0;
`endif

endmodule

// File: tb/tb_sar_search.sv
`timescale 1ns/1ps
module tb_sar_search;
    import sar_search_pkg::*;

    localparam int W = 4;
`ifdef SAR_SEARCH_STEP_CNT_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [W-1:0]       target = '0;
    logic [1:0]         force_mode = 2'd0;
    logic               fc_g, fc_e, fc_s;
    logic               cmp_g, cmp_e, cmp_s;
    logic [W-1:0]       guess, result;
    logic               busy, done, error;
    logic [STEPS_W-1:0] steps;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] exp_q[$];

    full_comp #(.WIDTH(W)) u_cmp (
        .a(target), .b(guess), .g(fc_g), .e(fc_e), .s(fc_s)
    );

    // Mode 1 forces "greater" forever, mode 2 forces an illegal g+e answer.
    always_comb begin
        cmp_g = fc_g;
        cmp_e = fc_e;
        cmp_s = fc_s;
        case (force_mode)
            2'd1: begin cmp_g = 1'b1; cmp_e = 1'b0; cmp_s = 1'b0; end
            2'd2: begin cmp_g = 1'b1; cmp_e = 1'b1; cmp_s = 1'b0; end
            default: ;
        endcase
    end

    sar_search #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_g(cmp_g), .cmp_e(cmp_e), .cmp_s(cmp_s),
        .guess(guess), .busy(busy), .done(done), .error(error),
        .result(result), .steps(steps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]      target;
        logic [1:0]        fmode;
        int                n_probes;
        logic [4:0][W-1:0] guesses;   // element 0 is the first probe
        logic              exp_done;
        logic              exp_error;
        logic [W-1:0]      exp_result;
        int                exp_steps;
        int                lat;       // cycles from the start cycle to the pulse
        int                poke;      // probe number at which to pulse start (0 = none)
    } vec_t;

    vec_t vecs[6];
    vec_t v4;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: condition not reached", nm);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int probes;
        bit fin;
        target     = v.target;
        force_mode = v.fmode;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < v.n_probes; i++) exp_q.push_back(v.guesses[i]);
        cyc = 0;
        probes = 0;
        fin = 1'b0;
        while (!fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) begin
                probes++;
                if (exp_q.size() == 0) fail_now({tag, "_extra_probe"});
                else chk({tag, "_guess"}, int'(guess), int'(exp_q.pop_front()));
                if (probes == v.poke) start = 1'b1;
            end else if (done || error) begin
                chk({tag, "_done"},    int'(done),   int'(v.exp_done));
                chk({tag, "_error"},   int'(error),  int'(v.exp_error));
                chk({tag, "_result"},  int'(result), int'(v.exp_result));
                chk({tag, "_steps"},   int'(steps),  STEP_EN ? v.exp_steps : 0);
                chk({tag, "_latency"}, cyc,          v.lat);
                fin = 1'b1;
            end else begin
                fail_now({tag, "_busy"});
                fin = 1'b1;
            end
        end
        start = 1'b0;
        if (!fin) fail_now({tag, "_timeout"});
        chk({tag, "_probes"}, probes, v.n_probes);
        exp_q.delete();
        if (v.poke > 0) begin
            repeat (2) begin
                @(negedge clk);
                chk({tag, "_start_not_queued"}, int'(busy), 0);
            end
        end
        force_mode = 2'd0;
    endtask

    initial begin
        //          target fmode n  guesses       done  err   result steps lat poke
        vecs[0] = '{4'd12, 2'd0, 4, 20'h0CDB7,   1'b1, 1'b0, 4'd12, 4,    5,  0};
        vecs[1] = '{4'd0,  2'd0, 4, 20'h00137,   1'b1, 1'b0, 4'd0,  4,    5,  0};
        vecs[2] = '{4'd15, 2'd0, 5, 20'hFEDB7,   1'b1, 1'b0, 4'd15, 5,    6,  0};
        vecs[3] = '{4'd5,  2'd1, 5, 20'hFEDB7,   1'b0, 1'b1, 4'd15, 5,    6,  0};
        vecs[4] = '{4'd5,  2'd2, 1, 20'h00007,   1'b0, 1'b1, 4'd15, 1,    2,  0};
        vecs[5] = '{4'd3,  2'd0, 2, 20'h00037,   1'b1, 1'b0, 4'd3,  2,    3,  2};
        v4      = '{4'd4,  2'd0, 4, 20'h04537,   1'b1, 1'b0, 4'd4,  4,    5,  0};

        // Reset state.
        #12;
        chk("rst_guess",  int'(guess),  0);
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        chk("rst_error",  int'(error),  0);
        chk("rst_result", int'(result), 0);
        chk("rst_steps",  int'(steps),  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_guess_hold", int'(guess), 0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Asynchronous reset in the middle of a search for 12 (at guess 11).
        target = 4'd12;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("arst_pre_guess", int'(guess), 11);
        #1 rst = 1'b1;
        #1;
        chk("arst_guess",  int'(guess),  0);
        chk("arst_busy",   int'(busy),   0);
        chk("arst_done",   int'(done),   0);
        chk("arst_error",  int'(error),  0);
        chk("arst_result", int'(result), 0);
        chk("arst_steps",  int'(steps),  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_pulse", int'(done || error || busy), 0);
        end

        run_vec(v4, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

endmodule
